// File: rtl/mulacc_pipe.sv
// Pipelined signed/unsigned multiplier with a running accumulator and valid/ready flow control.
// Input register -> STAGES product stages -> output register; one global enable stalls everything.
module mulacc_pipe #(
  parameter int N      = 8,
  parameter int M      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sgn,
  input  logic         acc,
  input  logic         clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out
);

  logic                   w_en, w_take;
  logic [STAGES:0]        r_vld_pipe;
  logic [N-1:0]           r_a, r_b;
  logic                   r_sgn, r_acc, r_clr;
  logic [M-1:0]           w_ax, w_bx, w_prod, w_res;
  logic [STAGES:1][M-1:0] r_p;
  logic [STAGES:1]        r_pacc, r_pclr;
  logic [M-1:0]           r_sum, r_out;
  logic                   r_out_vld;

  assign w_en      = !r_out_vld | out_ready;
  assign in_ready  = w_en & nreset;
  assign w_take    = in_valid & in_ready;
  assign out_valid = r_out_vld;
  assign out       = r_out;

  // Extending both operands to M bits before multiplying yields the 2N-bit product
  // already sign/zero-extended (M > 2N) or truncated (M <= 2N) to M bits.
  assign w_ax   = r_sgn ? M'($signed(r_a)) : M'(r_a);
  assign w_bx   = r_sgn ? M'($signed(r_b)) : M'(r_b);
  assign w_prod = w_ax * w_bx;

  assign w_res = (r_pacc[STAGES] && !r_pclr[STAGES]) ? r_sum + r_p[STAGES] : r_p[STAGES];

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_vld_pipe <= '0;
      r_out_vld  <= 1'b0;
      r_out      <= '0;
      r_sum      <= '0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_take};
      r_out_vld  <= r_vld_pipe[STAGES];
      // Sum only moves when a valid beat leaves, so stalls never double-count.
      if (r_vld_pipe[STAGES]) begin
        r_out <= w_res;
        if (r_pacc[STAGES]) r_sum <= w_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      if (w_take) begin
        r_a   <= a;
        r_b   <= b;
        r_sgn <= sgn;
        r_acc <= acc;
        r_clr <= clr;
      end
      r_p[1]    <= w_prod;
      r_pacc[1] <= r_acc;
      r_pclr[1] <= r_clr;
      for (int k = 2; k <= STAGES; k++) begin
        r_p[k]    <= r_p[k-1];
        r_pacc[k] <= r_pacc[k-1];
        r_pclr[k] <= r_pclr[k-1];
      end
    end
  end

endmodule

// File: tb/tb_mulacc_pipe.sv
// Bench for mulacc_pipe: directed cases plus randomized streams scored against a queue model.
module tb_mulacc_pipe;
  localparam int N = 8, M = 16, ST = 2, L = ST + 1;

  logic clk = 1'b0, nreset = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_ready, sgn = 1'b0, acc = 1'b0, clr = 1'b0;
  logic         out_valid, out_ready = 1'b1;
  logic [N-1:0] a = '0, b = '0;
  logic [M-1:0] out;
  logic         in_valid8 = 1'b0, in_ready8, sgn8 = 1'b0, acc8 = 1'b0, clr8 = 1'b0;
  logic         out_valid8, out_ready8 = 1'b1;
  logic [7:0]   a8 = '0, b8 = '0, out8;

  mulacc_pipe #(.N(N), .M(M), .STAGES(ST)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .acc(acc), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out(out));

  mulacc_pipe #(.N(8), .M(8), .STAGES(ST)) dut8 (
    .clk(clk), .nreset(nreset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sgn(sgn8), .acc(acc8), .clr(clr8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out(out8));

  int checks = 0, errors = 0;
  logic [M-1:0] exp_q[$], got_q[$];
  logic [M-1:0] m_acc = '0, mon_p;

  function automatic logic [M-1:0] ref_prod(logic [N-1:0] x, logic [N-1:0] y, logic s);
    longint p;
    if (s) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'(x) * longint'(y);
    return p[M-1:0];
  endfunction

  // Model: results in accept order; reset drops every beat not yet popped.
  always @(posedge clk) begin
    if (!nreset) begin
      while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
      m_acc = '0;
    end else begin
      if (out_valid && out_ready) got_q.push_back(out);
      if (in_valid && in_ready) begin
        mon_p = ref_prod(a, b, sgn);
        if (acc) begin
          m_acc = clr ? mon_p : m_acc + mon_p;
          exp_q.push_back(m_acc);
        end else exp_q.push_back(mon_p);
      end
    end
  end

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                      input logic ac, input logic cl);
    int guard = 0;
    a = x; b = y; sgn = s; acc = ac; clr = cl; in_valid = 1'b1;
    #2;
    while (!in_ready && guard < 50) begin @(negedge clk); #2; guard++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain;
    in_valid = 1'b0;
    repeat (L + 4) @(negedge clk);
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    checks++; if (out !== '0) begin errors++; $display("FAIL reset_out got %h required 0", out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b required 0", in_ready); end
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8 got %b required 0", out_valid8); end
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_signed;
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    a = 8'hFD; b = 8'd5; sgn = 1'b1; acc = 1'b0; clr = 1'b0; in_valid = 1'b1;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL signed_in_ready got %b required 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= L; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== (k == L)) begin
        errors++; $display("FAIL signed_latency edge+%0d out_valid=%b required %b", k, out_valid, k == L);
      end
    end
    checks++; if (out !== 16'hFFF1) begin errors++; $display("FAIL signed_mul out=%h required fff1", out); end
    @(negedge clk);
    drain();
  endtask

  task automatic test_unsigned;
    got_q.delete(); exp_q.delete();
    send(8'hFD, 8'd5, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL unsigned_count got %0d required 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 16'h04F1) begin errors++; $display("FAIL unsigned_fd5 out=%h required 04f1", got_q[0]); end
      checks++; if (got_q[1] !== 16'hFE01) begin errors++; $display("FAIL unsigned_ffff out=%h required fe01", got_q[1]); end
    end
  endtask

  task automatic test_backpressure;
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    fork
      for (int i = 0; i < 6; i++) send(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
      begin
        int g = 0;
        while (!out_valid && g < 20) begin @(negedge clk); g++; end
        out_ready = 1'b0;
        repeat (3) begin
          #2; checks++;
          if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b required 0", in_ready); end
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (got_q.size() != 6 || exp_q.size() != 6) begin
      errors++; $display("FAIL bp_count got %0d required 6 (model %0d)", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat[%0d] out=%h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_accumulate;
    logic [M-1:0] want [5] = '{16'd6, 16'd26, 16'd25, 16'd49, 16'd26};
    got_q.delete(); exp_q.delete();
    send(8'd2, 8'd3, 1'b1, 1'b1, 1'b1);
    send(8'd4, 8'd5, 1'b1, 1'b1, 1'b0);
    send(8'hFF, 8'd1, 1'b1, 1'b1, 1'b0);
    send(8'd7, 8'd7, 1'b1, 1'b0, 1'b0);
    send(8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 5) begin errors++; $display("FAIL acc_count got %0d required 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want[i]) begin errors++; $display("FAIL acc_beat[%0d] out=%h required %h", i, got_q[i], want[i]); end
    end
  endtask

  task automatic test_random;
    bit done = 1'b0;
    got_q.delete(); exp_q.delete();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0));
          if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin @(negedge clk); out_ready = ($urandom_range(0, 3) != 0); end
        out_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (got_q.size() != 40 || exp_q.size() != 40) begin
      errors++; $display("FAIL rand_count got %0d required 40 (model %0d)", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat[%0d] out=%h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic ac, input logic cl,
                      output logic [7:0] r, output logic ok);
    int g = 0;
    a8 = x; b8 = y; sgn8 = 1'b0; acc8 = ac; clr8 = cl; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    ok = 1'b0; r = '0;
    while (!ok && g < 10) begin
      @(posedge clk); #1; g++;
      if (out_valid8) begin r = out8; ok = 1'b1; end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap8;
    logic [7:0] r;
    logic ok;
    run8(8'd16, 8'd16, 1'b0, 1'b0, r, ok);
    checks++; if (!ok || r !== 8'h00) begin errors++; $display("FAIL wrap_16x16 out=%h valid=%b required 00", r, ok); end
    run8(8'h7F, 8'd2, 1'b1, 1'b1, r, ok);
    checks++; if (!ok || r !== 8'hFE) begin errors++; $display("FAIL wrap_clr out=%h valid=%b required fe", r, ok); end
    run8(8'd1, 8'd2, 1'b1, 1'b0, r, ok);
    checks++; if (!ok || r !== 8'h00) begin errors++; $display("FAIL wrap_acc out=%h valid=%b required 00", r, ok); end
  endtask

  task automatic test_reset_midstream;
    int bad = 0;
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    send(8'd5, 8'd5, 1'b0, 1'b1, 1'b1);
    send(8'd6, 8'd6, 1'b0, 1'b1, 1'b0);
    nreset = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b required 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got %b required 0", in_ready); end
    checks++; if (out !== '0) begin errors++; $display("FAIL rst_mid_out got %h required 0", out); end
    @(negedge clk);
    nreset = 1'b1;
    repeat (L + 3) begin @(posedge clk); #1; if (out_valid) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_stale got %0d stale beats required 0", bad); end
    @(negedge clk);
    send(8'd3, 8'd3, 1'b0, 1'b1, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'd9) begin
      errors++; $display("FAIL rst_mid_acc count=%0d out=%h required 1 beat of 0009",
                         got_q.size(), got_q.size() ? got_q[0] : 16'hxxxx);
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_backpressure();
    test_accumulate();
    test_random();
    test_wrap8();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
